axi4s_pkt_gen: RTL and testbench
================================

// Module: axi4s_pkt_gen
// PURPOSE
//  AXI4-stream master traffic generator; drives the stream bus that the axi4s debug monitor taps.
//  Emits a programmed number of fixed-length packets with a deterministic incrementing payload.
//  Honours tready backpressure; optional idle gap between packets.
//  Bring-up and bench source for exercising downstream slaves and monitor counters.
// PARAMETERS
//  TDATA_WIDTH   32  data bus width in bits, multiple of 8
//  TID_WIDTH     1   tid width
//  TDEST_WIDTH   4   tdest width
//  TUSER_WIDTH   4   tuser width
//  LEN_WIDTH     16  width of cfg_pkt_len, cfg_pkt_num and cfg_gap
// PORTS
//  axi4s_aclk     in   1                  clock, single domain
//  axi4s_areset   in   1                  reset, synchronous, active-high
//  cfg_start      in   1                  start pulse; ignored while busy
//  cfg_stop       in   1                  graceful stop request, honoured at packet boundary
//  cfg_pkt_len    in   LEN_WIDTH          beats per packet; 0 treated as 1
//  cfg_pkt_num    in   LEN_WIDTH          packets to send; 0 = continuous until stop
//  cfg_gap        in   LEN_WIDTH          idle cycles between packets
//  cfg_seed       in   TDATA_WIDTH        first tdata value
//  cfg_tid        in   TID_WIDTH          tid for the whole run
//  cfg_tdest      in   TDEST_WIDTH        tdest for the whole run
//  cfg_tuser      in   TUSER_WIDTH        tuser for the whole run
//  axi4s_tvalid   out  1                  master valid
//  axi4s_tready   in   1                  slave ready
//  axi4s_tdata    out  TDATA_WIDTH        payload
//  axi4s_tstrb    out  TDATA_WIDTH/8      all ones
//  axi4s_tkeep    out  TDATA_WIDTH/8      all ones
//  axi4s_tlast    out  1                  high on last beat of each packet
//  axi4s_tid      out  TID_WIDTH          latched cfg_tid
//  axi4s_tdest    out  TDEST_WIDTH        latched cfg_tdest
//  axi4s_tuser    out  TUSER_WIDTH        latched cfg_tuser
//  busy           out  1                  run in progress
//  done           out  1                  one-cycle pulse at end of run
//  beat_cnt       out  32                 beats handshaken this run, wraps
//  pkt_cnt        out  32                 tlast beats handshaken this run, wraps
// BEHAVIOUR
//  Reset: all outputs 0 (tstrb/tkeep included), FSM IDLE; wins over all other inputs; mid-packet reset
//   drops tvalid at the next edge with no tlast.
//  Handshake = tvalid & tready at a rising edge. Once tvalid is high, tvalid and all payload stay stable
//   until handshake. tvalid never depends combinationally on tready.
//  FSM IDLE: cfg_start latches all cfg_* inputs, clears beat_cnt/pkt_cnt, sets busy -> SEND.
//   tvalid is high the cycle after cfg_start.
//  SEND: tdata starts at seed and increments by 1 per handshake (mod 2^TDATA_WIDTH), continuing
//   across packets. tlast is high on beat pkt_len-1 of each packet.
//  On the tlast handshake:
//   - run complete (pkt_num reached, or stop pending) -> IDLE; done pulses and busy drops in the
//     cycle after that edge.
//   - else gap>0 -> GAP with tvalid low for exactly gap cycles, then SEND.
//   - else gap=0 -> stay in SEND; tvalid stays high, next packet back-to-back.
//  cfg_stop in IDLE has no effect. cfg_stop in SEND/GAP latches a stop-pending flag. In SEND, the current
//   packet finishes. In GAP, go to IDLE immediately with done. A packet is never truncated.
//  cfg_start while busy is ignored, including in the done cycle. cfg_start and cfg_stop together in IDLE
//   start the run with no stop pending.
//  Counters: beat_cnt += 1 per handshake; pkt_cnt += 1 per tlast handshake. Both are held after done
//   until the next start or reset.
//  Beat and packet indices are LEN_WIDTH wide; pkt_len = 2^LEN_WIDTH-1 must work without overflow.
// STRUCTURE
//  Shared package axi4s_pkg holds the FSM state encoding (IDLE/SEND/GAP) and a STRB_W = TDATA_WIDTH/8 helper.
//  Flat module: FSM, beat/packet/gap counters and payload register in one file. No sub-module.
// TESTING
//  len=4,num=2,gap=0,seed=0x10, tready=1 -> 8 contiguous beats 0x10..0x17; tlast on 0x13,0x17;
//   done 1 cycle after last handshake; pkt_cnt=2, beat_cnt=8.
//  len=3,num=1, tready toggles 1010 -> tdata/tlast held across stalls; 3 handshakes; beat_cnt=3.
//  len=2,num=2,gap=3 -> exactly 3 idle tvalid-low cycles between the packets.
//  num=0,len=5, cfg_stop mid 2nd packet -> 2nd packet completes (tlast beat 10), done, pkt_cnt=2.
//  len=0,num=3 -> three 1-beat packets, each tlast=1.
//  reset asserted mid-packet, and cfg_start while busy -> all outputs 0 next cycle; the extra start is ignored.

Source files
------------

// File: rtl/axi4s_pkg.sv
// rtl/axi4s_pkg.sv - shared FSM encoding and width helpers for the axi4s blocks
package axi4s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } gen_state_t;

    // Byte-lane count for a given data bus width
    function automatic int strb_w(input int tdata_width);
        return tdata_width / 8;
    endfunction

endpackage

// File: rtl/axi4s_pkt_gen.sv
// rtl/axi4s_pkt_gen.sv - AXI4-stream master packet generator with incrementing payload
module axi4s_pkt_gen
    import axi4s_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 4,
    parameter int TUSER_WIDTH = 4,
    parameter int LEN_WIDTH   = 16
) (
    input  logic                        axi4s_aclk,
    input  logic                        axi4s_areset,
    input  logic                        cfg_start,
    input  logic                        cfg_stop,
    input  logic [LEN_WIDTH-1:0]        cfg_pkt_len,
    input  logic [LEN_WIDTH-1:0]        cfg_pkt_num,
    input  logic [LEN_WIDTH-1:0]        cfg_gap,
    input  logic [TDATA_WIDTH-1:0]      cfg_seed,
    input  logic [TID_WIDTH-1:0]        cfg_tid,
    input  logic [TDEST_WIDTH-1:0]      cfg_tdest,
    input  logic [TUSER_WIDTH-1:0]      cfg_tuser,
    output logic                        axi4s_tvalid,
    input  logic                        axi4s_tready,
    output logic [TDATA_WIDTH-1:0]      axi4s_tdata,
    output logic [TDATA_WIDTH/8-1:0]    axi4s_tstrb,
    output logic [TDATA_WIDTH/8-1:0]    axi4s_tkeep,
    output logic                        axi4s_tlast,
    output logic [TID_WIDTH-1:0]        axi4s_tid,
    output logic [TDEST_WIDTH-1:0]      axi4s_tdest,
    output logic [TUSER_WIDTH-1:0]      axi4s_tuser,
    output logic                        busy,
    output logic                        done,
    output logic [31:0]                 beat_cnt,
    output logic [31:0]                 pkt_cnt
);

    localparam int                 STRB_W = strb_w(TDATA_WIDTH);
    localparam logic [LEN_WIDTH-1:0] ONE  = LEN_WIDTH'(1);

    gen_state_t state_q, state_d;

    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q, tlast_d;
    logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [STRB_W-1:0]      keep_q, keep_d;
    logic [TID_WIDTH-1:0]   tid_q, tid_d;
    logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   num_q, num_d;
    logic [LEN_WIDTH-1:0]   gap_q, gap_d;
    logic [LEN_WIDTH-1:0]   beat_idx_q, beat_idx_d;
    logic [LEN_WIDTH-1:0]   pkt_idx_q, pkt_idx_d;
    logic [LEN_WIDTH-1:0]   gap_cnt_q, gap_cnt_d;
    logic                   stop_q, stop_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [31:0]            beat_cnt_q, beat_cnt_d;
    logic [31:0]            pkt_cnt_q, pkt_cnt_d;

    logic                   hs;
    logic                   stop_eff;
    logic                   start_ok;
    logic                   run_end;
    logic [LEN_WIDTH-1:0]   len_eff;

    assign hs       = tvalid_q & axi4s_tready;
    assign stop_eff = stop_q | cfg_stop;
    // The done cycle is still treated as busy for start purposes
    assign start_ok = cfg_start & ~done_q;
    assign run_end  = stop_eff | ((num_q != '0) && (pkt_idx_q == num_q - ONE));
    assign len_eff  = (cfg_pkt_len == '0) ? ONE : cfg_pkt_len;

    // State register
    always_ff @(posedge axi4s_aclk) begin
        if (axi4s_areset) state_q <= ST_IDLE;
        else              state_q <= state_d;
    end

    // Next-state: run starts on accepted start, ends only at a packet boundary or in a gap
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_SEND;
            ST_SEND: begin
                if (hs && tlast_q) begin
                    if (run_end)           state_d = ST_IDLE;
                    else if (gap_q != '0)  state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (stop_eff)              state_d = ST_IDLE;
                else if (gap_cnt_q <= ONE) state_d = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath: payload only advances on a handshake so the bus holds across stalls
    always_comb begin
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        keep_d     = '1;
        tid_d      = tid_q;
        tdest_d    = tdest_q;
        tuser_d    = tuser_q;
        len_d      = len_q;
        num_d      = num_q;
        gap_d      = gap_q;
        beat_idx_d = beat_idx_q;
        pkt_idx_d  = pkt_idx_q;
        gap_cnt_d  = gap_cnt_q;
        stop_d     = stop_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    len_d      = len_eff;
                    num_d      = cfg_pkt_num;
                    gap_d      = cfg_gap;
                    tid_d      = cfg_tid;
                    tdest_d    = cfg_tdest;
                    tuser_d    = cfg_tuser;
                    tdata_d    = cfg_seed;
                    tvalid_d   = 1'b1;
                    tlast_d    = (len_eff == ONE);
                    beat_idx_d = '0;
                    pkt_idx_d  = '0;
                    beat_cnt_d = '0;
                    pkt_cnt_d  = '0;
                    stop_d     = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            ST_SEND: begin
                stop_d = stop_eff;
                if (hs) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    tdata_d    = tdata_q + TDATA_WIDTH'(1);
                    if (tlast_q) begin
                        pkt_cnt_d  = pkt_cnt_q + 32'd1;
                        pkt_idx_d  = pkt_idx_q + ONE;
                        beat_idx_d = '0;
                        if (run_end) begin
                            tvalid_d = 1'b0;
                            tlast_d  = 1'b0;
                            busy_d   = 1'b0;
                            done_d   = 1'b1;
                            stop_d   = 1'b0;
                        end else if (gap_q != '0) begin
                            tvalid_d  = 1'b0;
                            tlast_d   = 1'b0;
                            gap_cnt_d = gap_q;
                        end else begin
                            tvalid_d = 1'b1;
                            tlast_d  = (len_q == ONE);
                        end
                    end else begin
                        beat_idx_d = beat_idx_q + ONE;
                        tlast_d    = (beat_idx_q + ONE == len_q - ONE);
                    end
                end
            end
            ST_GAP: begin
                if (stop_eff) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    stop_d = 1'b0;
                end else if (gap_cnt_q <= ONE) begin
                    tvalid_d = 1'b1;
                    tlast_d  = (len_q == ONE);
                end else begin
                    gap_cnt_d = gap_cnt_q - ONE;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears every output including tstrb/tkeep
    always_ff @(posedge axi4s_aclk) begin
        if (axi4s_areset) begin
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            keep_q     <= '0;
            tid_q      <= '0;
            tdest_q    <= '0;
            tuser_q    <= '0;
            len_q      <= '0;
            num_q      <= '0;
            gap_q      <= '0;
            beat_idx_q <= '0;
            pkt_idx_q  <= '0;
            gap_cnt_q  <= '0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            keep_q     <= keep_d;
            tid_q      <= tid_d;
            tdest_q    <= tdest_d;
            tuser_q    <= tuser_d;
            len_q      <= len_d;
            num_q      <= num_d;
            gap_q      <= gap_d;
            beat_idx_q <= beat_idx_d;
            pkt_idx_q  <= pkt_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    assign axi4s_tvalid = tvalid_q;
    assign axi4s_tlast  = tlast_q;
    assign axi4s_tdata  = tdata_q;
    assign axi4s_tstrb  = keep_q;
    assign axi4s_tkeep  = keep_q;
    assign axi4s_tid    = tid_q;
    assign axi4s_tdest  = tdest_q;
    assign axi4s_tuser  = tuser_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign beat_cnt     = beat_cnt_q;
    assign pkt_cnt      = pkt_cnt_q;

endmodule

// File: tb/tb_axi4s_pkt_gen.sv
// tb/tb_axi4s_pkt_gen.sv - scoreboard bench for axi4s_pkt_gen
module tb_axi4s_pkt_gen;

    logic        clk = 1'b0;
    logic        areset;
    logic        cfg_start, cfg_stop;
    logic [15:0] cfg_pkt_len, cfg_pkt_num, cfg_gap;
    logic [31:0] cfg_seed;
    logic        cfg_tid;
    logic [3:0]  cfg_tdest, cfg_tuser;
    logic        tvalid, tready, tlast;
    logic [31:0] tdata;
    logic [3:0]  tstrb, tkeep;
    logic        tid;
    logic [3:0]  tdest, tuser;
    logic        busy, done;
    logic [31:0] beat_cnt, pkt_cnt;

    always #5 clk = ~clk;

    axi4s_pkt_gen dut (
        .axi4s_aclk   (clk),
        .axi4s_areset (areset),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_pkt_len  (cfg_pkt_len),
        .cfg_pkt_num  (cfg_pkt_num),
        .cfg_gap      (cfg_gap),
        .cfg_seed     (cfg_seed),
        .cfg_tid      (cfg_tid),
        .cfg_tdest    (cfg_tdest),
        .cfg_tuser    (cfg_tuser),
        .axi4s_tvalid (tvalid),
        .axi4s_tready (tready),
        .axi4s_tdata  (tdata),
        .axi4s_tstrb  (tstrb),
        .axi4s_tkeep  (tkeep),
        .axi4s_tlast  (tlast),
        .axi4s_tid    (tid),
        .axi4s_tdest  (tdest),
        .axi4s_tuser  (tuser),
        .busy         (busy),
        .done         (done),
        .beat_cnt     (beat_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    typedef logic [41:0] beat_t;
    beat_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_hs_cyc = 0;
    int low_run = 0;
    int last_low = 0;
    bit rdy_toggle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Backpressure driver
    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_toggle) tready = ~tready;
    end

    // Monitor: pops expected beats on each handshake, checks hold stability and gap length
    initial begin
        beat_t bus, held, e;
        bit    hold = 0;
        forever begin
            @(negedge clk);
            if (areset) begin
                hold    = 0;
                low_run = 0;
            end else begin
                bus = {tlast, tid, tdest, tuser, tdata};
                if (hold) begin
                    chk("hold_stable", {21'd0, tvalid, bus}, {21'd0, 1'b1, held});
                    hold = 0;
                end
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", 64'(bus), 64'(e));
                    end
                    last_hs_cyc = cyc;
                end else if (tvalid) begin
                    hold = 1;
                    held = bus;
                end
                if (busy && !tvalid) low_run++;
                else if (tvalid) begin
                    if (low_run > 0) last_low = low_run;
                    low_run = 0;
                end
            end
        end
    end

    task automatic start_run(input logic [15:0] len, input logic [15:0] num, input logic [15:0] gap,
                             input logic [31:0] seed, input logic t_id, input logic [3:0] t_dest,
                             input logic [3:0] t_user, input int n_pkts);
        int          le;
        logic [31:0] d;
        tick();
        le = (len == 0) ? 1 : int'(len);
        d  = seed;
        for (int p = 0; p < n_pkts; p++) begin
            for (int b = 0; b < le; b++) begin
                exp_q.push_back({(b == le - 1), t_id, t_dest, t_user, d});
                d = d + 32'd1;
            end
        end
        cfg_pkt_len = len;
        cfg_pkt_num = num;
        cfg_gap     = gap;
        cfg_seed    = seed;
        cfg_tid     = t_id;
        cfg_tdest   = t_dest;
        cfg_tuser   = t_user;
        cfg_start   = 1'b1;
        tick();
        cfg_start   = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        bit found = 0;
        dc = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (done) begin
                found = 1;
                dc    = cyc;
                break;
            end
        end
        chk("done_seen", 64'(found), 64'd1);
    endtask

    initial begin
        int  dc;
        bit  hit;
        areset      = 1'b1;
        cfg_start   = 1'b0;
        cfg_stop    = 1'b0;
        cfg_pkt_len = '0;
        cfg_pkt_num = '0;
        cfg_gap     = '0;
        cfg_seed    = '0;
        cfg_tid     = '0;
        cfg_tdest   = '0;
        cfg_tuser   = '0;
        tready      = 1'b1;
        tick();
        tick();
        chk("rst_outputs", {tvalid, tlast, tdata, tstrb, tkeep, busy, done},
            {1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0});
        chk("rst_counters", {beat_cnt, pkt_cnt}, 64'd0);
        areset = 1'b0;

        // len=4 num=2 gap=0: 8 contiguous beats, tlast on 0x13 and 0x17
        start_run(16'd4, 16'd2, 16'd0, 32'h10, 1'b1, 4'h5, 4'hA, 2);
        chk("t1_busy_valid", {busy, tvalid}, 2'b11);
        chk("t1_keep_strb", {tkeep, tstrb}, 8'hFF);
        wait_done(dc);
        chk("t1_done_latency", 64'(dc), 64'(last_hs_cyc + 1));
        chk("t1_busy_in_done", 64'(busy), 64'd0);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("t1_start_in_done_ignored", {done, busy, tvalid}, 3'b000);
        chk("t1_counts", {beat_cnt, pkt_cnt}, {32'd8, 32'd2});
        chk("t1_queue_empty", 64'(exp_q.size()), 64'd0);

        // len=3 num=1 with alternating tready
        tready     = 1'b1;
        rdy_toggle = 1;
        start_run(16'd3, 16'd1, 16'd0, 32'hABCD0000, 1'b0, 4'h3, 4'h1, 1);
        wait_done(dc);
        rdy_toggle = 0;
        tready     = 1'b1;
        chk("t2_beat_cnt", 64'(beat_cnt), 64'd3);
        chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // len=2 num=2 gap=3: three idle cycles between packets
        last_low = 0;
        start_run(16'd2, 16'd2, 16'd3, 32'h40, 1'b1, 4'h9, 4'h2, 2);
        wait_done(dc);
        chk("t3_gap_cycles", 64'(last_low), 64'd3);
        chk("t3_counts", {beat_cnt, pkt_cnt}, {32'd4, 32'd2});

        // continuous len=5, stop inside 2nd packet: packet completes
        start_run(16'd5, 16'd0, 16'd0, 32'h100, 1'b0, 4'h7, 4'h4, 2);
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            if (beat_cnt == 32'd7) begin
                hit = 1;
                break;
            end
            tick();
        end
        chk("t4_reached_beat7", 64'(hit), 64'd1);
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        wait_done(dc);
        chk("t4_counts", {beat_cnt, pkt_cnt}, {32'd10, 32'd2});
        chk("t4_queue_empty", 64'(exp_q.size()), 64'd0);

        // len=0 num=3: three single-beat packets, payload wraps
        start_run(16'd0, 16'd3, 16'd0, 32'hFFFFFFFE, 1'b1, 4'hC, 4'hF, 3);
        wait_done(dc);
        chk("t5_counts", {beat_cnt, pkt_cnt}, {32'd3, 32'd3});

        // extra start while busy is ignored; reset mid-packet clears everything
        start_run(16'd8, 16'd1, 16'd0, 32'h200, 1'b0, 4'h1, 4'h6, 1);
        tick();
        cfg_seed  = 32'hDEAD;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        chk("t6_midpkt", {busy, tvalid}, 2'b11);
        areset = 1'b1;
        tick();
        chk("t6_rst_outputs", {tvalid, tlast, tdata, tstrb, tkeep, busy, done},
            {1'b0, 1'b0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0});
        chk("t6_rst_counters", {beat_cnt, pkt_cnt}, 64'd0);
        exp_q.delete();
        areset = 1'b0;

        // recovery run after reset
        start_run(16'd2, 16'd1, 16'd0, 32'h300, 1'b1, 4'h2, 4'h3, 1);
        wait_done(dc);
        chk("t7_counts", {beat_cnt, pkt_cnt}, {32'd2, 32'd1});
        chk("t7_queue_empty", 64'(exp_q.size()), 64'd0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
